// File: rtl/call_scheduler.sv
// Hall-call scheduler: latches floor calls, clears them on door service, and
// picks the next target floor using an up/down sweep with motor-direction guards.
module call_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn,
  input  logic [2:0] current_floor,
  input  logic       door_open,
  input  logic       motor_up,
  input  logic       motor_down,
  output logic [4:0] req,
  output logic [4:0] pending,
  output logic [2:0] pending_count,
  output logic [1:0] dir,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    SERVE_UP   = 2'b01,
    SERVE_DOWN = 2'b10
  } dir_t;

  logic [4:0] pending_q, pending_d;
  logic [2:0] count_q, count_d;
  logic [4:0] req_q, req_d;
  dir_t       dir_q, dir_d;
  logic       fault_q, fault_d;

  logic       floor_valid;
  logic [4:0] cur_onehot;
  logic [4:0] clr;
  logic       motors_both;
  logic       up_guard;
  logic       dn_guard;

  assign floor_valid = (current_floor <= 3'd4);
  assign cur_onehot  = floor_valid ? (5'b00001 << current_floor) : 5'b00000;
  assign clr         = door_open ? cur_onehot : 5'b00000;
  // Both motor flags at once is nonsense; neither guard applies then.
  assign motors_both = motor_up & motor_down;
  assign up_guard    = motor_up & ~motor_down;
  assign dn_guard    = motor_down & ~motor_up;

  // Call latching: a clear in the same cycle as a press wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pending_d = (pending_q | btn) & ~clr;
    count_d   = 3'd0;
    for (int i = 0; i < 5; i++) begin
      count_d = count_d + 3'(pending_d[i]);
    end
    fault_d = fault_q | ~floor_valid | motors_both;
  end

  logic       above_found, below_found;
  logic [2:0] above_floor, below_floor;
  logic       cand_found;
  logic [2:0] cand_floor;
  dir_t       cand_dir;
  logic       blocked;

  // Nearest pending floor strictly above and strictly below the cabin.
  always_comb begin
    above_found = 1'b0;
    above_floor = 3'd0;
    below_found = 1'b0;
    below_floor = 3'd0;
    for (int f = 4; f >= 0; f--) begin
      if (pending_q[f] && (3'(f) > current_floor)) begin
        above_found = 1'b1;
        above_floor = 3'(f);
      end
    end
    for (int f = 0; f < 5; f++) begin
      if (pending_q[f] && (3'(f) < current_floor)) begin
        below_found = 1'b1;
        below_floor = 3'(f);
      end
    end
  end

  // Candidate target according to the sweep direction.
  always_comb begin
    cand_found = 1'b0;
    cand_floor = 3'd0;
    cand_dir   = dir_q;
    unique case (dir_q)
      SERVE_UP: begin
        if (above_found) begin
          cand_found = 1'b1; cand_floor = above_floor; cand_dir = SERVE_UP;
        end else if (below_found) begin
          cand_found = 1'b1; cand_floor = below_floor; cand_dir = SERVE_DOWN;
        end
      end
      SERVE_DOWN: begin
        if (below_found) begin
          cand_found = 1'b1; cand_floor = below_floor; cand_dir = SERVE_DOWN;
        end else if (above_found) begin
          cand_found = 1'b1; cand_floor = above_floor; cand_dir = SERVE_UP;
        end
      end
      default: begin
        // Equal distance goes to the lower floor.
        if (below_found && (!above_found ||
            ((current_floor - below_floor) <= (above_floor - current_floor)))) begin
          cand_found = 1'b1; cand_floor = below_floor; cand_dir = SERVE_DOWN;
        end else if (above_found) begin
          cand_found = 1'b1; cand_floor = above_floor; cand_dir = SERVE_UP;
        end
      end
    endcase
  end

  // Final selection: out-of-range floor and motor-guard violations hold state.
  always_comb begin
    req_d   = req_q;
    dir_d   = dir_q;
    blocked = (up_guard && (cand_floor < current_floor)) ||
              (dn_guard && (cand_floor > current_floor));
    if (!floor_valid) begin
      req_d = req_q;
      dir_d = dir_q;
    end else if (pending_q == 5'b00000) begin
      req_d = 5'b00000;
      dir_d = IDLE;
    end else if (|(pending_q & cur_onehot)) begin
      req_d = cur_onehot;
    end else if (cand_found && !blocked) begin
      req_d = 5'b00001 << cand_floor;
      dir_d = cand_dir;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      pending_q <= 5'b00000;
      count_q   <= 3'd0;
      req_q     <= 5'b00000;
      dir_q     <= IDLE;
      fault_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      req_q     <= req_d;
      dir_q     <= dir_d;
      fault_q   <= fault_d;
    end
  end

  assign req           = req_q;
  assign pending       = pending_q;
  assign pending_count = count_q;
  assign dir           = dir_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_call_scheduler.sv
// Self-checking bench for call_scheduler: a distance-based reference model is
// compared every cycle, plus hand-computed expectations for directed scenarios.
module tb_call_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn;
  logic [2:0] current_floor;
  logic       door_open, motor_up, motor_down;
  logic [4:0] req, pending;
  logic [2:0] pending_count;
  logic [1:0] dir;
  logic       fault;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [4:0] m_pending = '0;
  logic [4:0] m_req     = '0;
  logic [1:0] m_dir     = '0;
  logic [2:0] m_count   = '0;
  logic       m_fault   = 1'b0;

  call_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .current_floor (current_floor),
    .door_open     (door_open),
    .motor_up      (motor_up),
    .motor_down    (motor_down),
    .req           (req),
    .pending       (pending),
    .pending_count (pending_count),
    .dir           (dir),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next state from the current inputs and the model's state.
  always @(posedge clk) begin
    int cf, tgt, up_t, dn_t;
    logic [4:0] clr, new_p;
    bit valid, eu, ed;
    if (reset) begin
      m_pending = '0; m_req = '0; m_dir = 2'b00; m_count = '0; m_fault = 1'b0;
    end else begin
      cf    = int'(current_floor);
      valid = (cf <= 4);
      clr   = (door_open && valid) ? 5'(1 << cf) : 5'b0;
      new_p = (m_pending | btn) & ~clr;
      eu    = motor_up && !motor_down;
      ed    = motor_down && !motor_up;
      if (!valid) begin
        // hold req and dir
      end else if (m_pending == 5'b0) begin
        m_req = '0; m_dir = 2'b00;
      end else if (m_pending[cf]) begin
        m_req = 5'(1 << cf);
      end else begin
        up_t = -1; dn_t = -1; tgt = -1;
        for (int d = 1; d <= 4; d++) begin
          if (up_t < 0 && cf + d <= 4 && m_pending[cf + d]) up_t = cf + d;
          if (dn_t < 0 && cf - d >= 0 && m_pending[cf - d]) dn_t = cf - d;
        end
        if (m_dir == 2'b01)      tgt = (up_t >= 0) ? up_t : dn_t;
        else if (m_dir == 2'b10) tgt = (dn_t >= 0) ? dn_t : up_t;
        else begin
          for (int d = 1; d <= 4; d++) begin
            if (tgt < 0 && cf - d >= 0 && m_pending[cf - d]) tgt = cf - d;
            else if (tgt < 0 && cf + d <= 4 && m_pending[cf + d]) tgt = cf + d;
          end
        end
        if (!((eu && tgt < cf) || (ed && tgt > cf))) begin
          m_req = 5'(1 << tgt);
          m_dir = (tgt > cf) ? 2'b01 : 2'b10;
        end
      end
      m_pending = new_p;
      m_count   = 3'($countones(new_p));
      m_fault   = m_fault | !valid | (motor_up && motor_down);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_pending", 8'(pending), 8'(m_pending));
      check("cyc_count",   8'(pending_count), 8'(m_count));
      check("cyc_req",     8'(req), 8'(m_req));
      check("cyc_dir",     8'(dir), 8'(m_dir));
      check("cyc_fault",   8'(fault), 8'(m_fault));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; btn = '0; current_floor = '0;
    door_open = 1'b0; motor_up = 1'b0; motor_down = 1'b0;
    tick(); tick();
    cmp_en = 1'b1;
    check("rst_pending", 8'(pending), 8'h00);
    check("rst_count",   8'(pending_count), 8'h00);
    check("rst_req",     8'(req), 8'h00);
    check("rst_dir",     8'(dir), 8'h00);
    check("rst_fault",   8'(fault), 8'h00);

    // Idle at floor 0, single press for floor 2
    reset = 1'b0; btn = 5'b00100; tick();
    check("s1_pending", 8'(pending), 8'b00100);
    check("s1_count",   8'(pending_count), 8'd1);
    check("s1_req_lat", 8'(req), 8'h00);
    btn = '0; tick();
    check("s1_req", 8'(req), 8'b00100);
    check("s1_dir", 8'(dir), 8'b01);

    // Build pending=10001 while serving floor 2, then sweep up with motor_up
    current_floor = 3'd2; door_open = 1'b1; btn = 5'b10001; tick();
    check("s2_pending", 8'(pending), 8'b10001);
    door_open = 1'b0; btn = '0; current_floor = 3'd1; motor_up = 1'b1; tick();
    check("s2_req_up", 8'(req), 8'b10000);
    check("s2_dir_up", 8'(dir), 8'b01);
    current_floor = 3'd4; door_open = 1'b1; tick();
    check("s2_clr4", 8'(pending), 8'b00001);
    door_open = 1'b0; tick();
    check("s2_guard_req", 8'(req), 8'b10000);
    check("s2_guard_dir", 8'(dir), 8'b01);
    motor_up = 1'b0; tick();
    check("s2_rev_req", 8'(req), 8'b00001);
    check("s2_rev_dir", 8'(dir), 8'b10);

    // Mirror guard with motor_down
    current_floor = 3'd2; motor_down = 1'b1; btn = 5'b01000; tick();
    btn = '0; tick();
    check("s2m_req", 8'(req), 8'b00001);
    current_floor = 3'd0; door_open = 1'b1; tick();
    door_open = 1'b0; tick();
    check("s2m_guard_req", 8'(req), 8'b00001);
    check("s2m_guard_dir", 8'(dir), 8'b10);
    motor_down = 1'b0; tick();
    check("s2m_rev_req", 8'(req), 8'b01000);
    check("s2m_rev_dir", 8'(dir), 8'b01);
    current_floor = 3'd3; door_open = 1'b1; tick();
    door_open = 1'b0; tick();
    check("s2_idle_req", 8'(req), 8'h00);
    check("s2_idle_dir", 8'(dir), 8'b00);

    // Idle tie at floor 2 between floors 1 and 3
    current_floor = 3'd2; btn = 5'b01010; tick();
    check("s3_count", 8'(pending_count), 8'd2);
    btn = '0; tick();
    check("s3_req", 8'(req), 8'b00010);
    check("s3_dir", 8'(dir), 8'b10);

    // Press arriving with the clear of the same floor is dropped
    current_floor = 3'd3; door_open = 1'b1; btn = 5'b01000; tick();
    check("s4_pending_a", 8'(pending), 8'b00010);
    tick();
    check("s4_pending_b", 8'(pending), 8'b00010);
    check("s4_count_b",   8'(pending_count), 8'd1);
    door_open = 1'b0; btn = 5'b00010; tick();
    check("s4_repress_count", 8'(pending_count), 8'd1);

    // Out-of-range floor raises sticky fault, no clear
    btn = '0; current_floor = 3'd5; door_open = 1'b1; tick();
    check("s5_fault",   8'(fault), 8'h01);
    check("s5_pending", 8'(pending), 8'b00010);
    current_floor = 3'd1; door_open = 1'b0; tick();
    check("s5_sticky", 8'(fault), 8'h01);
    reset = 1'b1; tick();
    check("s5_rst_fault", 8'(fault), 8'h00);
    reset = 1'b0;

    // Both motors flagged is a fault; then reset mid-sweep with presses held
    current_floor = 3'd0; motor_up = 1'b1; motor_down = 1'b1; btn = 5'b11011; tick();
    check("s6_both_fault", 8'(fault), 8'h01);
    check("s6_count", 8'(pending_count), 8'd4);
    motor_up = 1'b0; motor_down = 1'b0; btn = '0; current_floor = 3'd2; tick();
    tick();
    check("s6_sweep_dir", 8'(dir), 8'b10);
    reset = 1'b1; btn = 5'b11111; tick();
    check("s6_pending", 8'(pending), 8'h00);
    check("s6_count0",  8'(pending_count), 8'h00);
    check("s6_req",     8'(req), 8'h00);
    check("s6_dir",     8'(dir), 8'h00);
    check("s6_fault",   8'(fault), 8'h00);
    reset = 1'b0; btn = 5'b00100; tick();
    check("s6_post_pending", 8'(pending), 8'b00100);
    btn = '0; tick(); tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/call_scheduler.md
CALL_SCHEDULER -- requirements
Module: call_scheduler

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 Ports SHALL be as follows:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- btn  input  5  call buttons, bit n = floor n, level or pulse
- current_floor  input  3  cabin floor, valid range 0..4
- door_open  input  1  cabin door open at current_floor (service event)
- motor_up  input  1  cabin moving up
- motor_down  input  1  cabin moving down
- req  output  5  one-hot target floor for the elevator controller, 0 = none
- pending  output  5  latched outstanding calls
- pending_count  output  3  population count of pending, 0..5
- dir  output  2  sweep state: 00 IDLE, 01 SERVE_UP, 10 SERVE_DOWN
- fault  output  1  sticky, current_floor out of range seen

Function
REQ-003 All outputs SHALL be registered, and every output SHALL update only on the rising edge of clk.
REQ-004 Each edge SHALL apply pending <= (pending | btn) & ~clr, where clr is one-hot(current_floor) when door_open=1 and current_floor<=4, and 0 otherwise.
REQ-005 A button press for floor f SHALL be dropped when it arrives in the same cycle that floor f is cleared; the clear SHALL win.
REQ-006 A press on an already-pending floor SHALL have no effect.
REQ-007 pending_count SHALL equal the popcount of the new pending value and SHALL update in the same cycle as pending.
REQ-008 Selection SHALL use the registered pending, dir and current_floor, and SHALL assign its result to req on the next edge (one-cycle latency from pending to req).
REQ-009 Selection priority 1: if pending[current_floor]=1, the module SHALL select current_floor, regardless of dir.
REQ-010 In SERVE_UP, the module SHALL select the lowest pending floor above current_floor; if none exists, it SHALL select the highest pending floor below current_floor and set dir to SERVE_DOWN; if no floor is pending, it SHALL set req=0 and dir to IDLE.
REQ-011 In SERVE_DOWN, the module SHALL behave as the mirror of REQ-010: select the highest pending floor below, else the lowest pending floor above with dir set to SERVE_UP, else req=0 and dir to IDLE.
REQ-012 In IDLE, the module SHALL select the nearest pending floor, with a distance tie going to the lower floor; dir SHALL become SERVE_UP if that floor is above current_floor, SERVE_DOWN if below, and stay IDLE if it equals current_floor.
REQ-013 While motor_up=1, the module SHALL NOT switch dir to SERVE_DOWN, and req SHALL only name floors >= current_floor; motor_down=1 SHALL be the mirror.
REQ-014 If the motor guard blocks a reversal, the module SHALL hold the previous req and dir.
REQ-015 req SHALL always be one-hot or zero.
REQ-016 req SHALL be zero when pending is zero.
REQ-017 When current_floor>4, the module SHALL set fault=1, treat the cycle as having no clear, and hold req and dir.
REQ-018 fault SHALL stay 1 until reset.
REQ-019 When motor_up and motor_down are both 1, the module SHALL treat both as 0 for REQ-013 and SHALL set fault=1.

Reset
REQ-020 When reset=1 on an edge, the module SHALL set pending=0, pending_count=0, req=0, dir=IDLE and fault=0.
REQ-021 Reset SHALL take priority over btn, door_open and every other input.
REQ-022 When reset is asserted mid-sweep, the module SHALL discard all calls, and presses in the reset cycle SHALL be lost.
REQ-023 In the first edge after reset deasserts, the module SHALL latch btn normally.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- IDLE, floor 0, btn=00100 for 1 cycle -> pending=00100 next edge, req=00100, dir=01 one edge later, pending_count=1.
- SERVE_UP at floor 1, pending=10001, motor_up=1 -> req=10000, dir stays 01; floor 4 with door_open=1 -> pending=00001, then req=00001, dir=10.
- IDLE at floor 2, pending=01010 -> tie between floors 1 and 3 resolves to req=00010, dir=10.
- Floor 3, door_open=1, btn=01000 in the same cycle -> pending[3]=0 afterwards, pending_count unchanged by the press.
- current_floor=5 for 1 cycle with door_open=1 -> fault=1, pending unchanged; fault stays 1 until reset, then reads 0.
- Sweep in progress with pending=11011 and reset pulsed 1 cycle -> all outputs zero/IDLE at the next edge, with btn ignored in that cycle.
